// File: rtl/fp_pkg.sv
// Shared floating-point constants and IEEE-754 single field helpers used by
// the divider, multiplier and adder.
package fp_pkg;

  localparam int DIV_STEPS = 26;
  localparam int EXP_BIAS  = 127;
  localparam logic [30:0] FP_INF_MAG = 31'h7F800000;

  function automatic logic fp_sign(input logic [31:0] f);
    return f[31];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] f);
    return f[30:23];
  endfunction

  // Hidden bit is always set; zero/denormal operands are caught by exponent.
  function automatic logic [23:0] fp_mant(input logic [31:0] f);
    return {1'b1, f[22:0]};
  endfunction

endpackage

// File: rtl/fp_divider.sv
// Multi-cycle IEEE single divider: restoring mantissa division, one quotient
// bit per cycle, stalling the CPU until all DIV_STEPS bits are produced.
module fp_divider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        stall,
  output logic [31:0] z
);

  logic [4:0]  s;
  logic [24:0] r;
  logic [25:0] q;

  logic [24:0] a;
  logic [25:0] diff;
  logic        qbit;
  logic        done;

  logic              sgn;
  logic              x_zero;
  logic              y_zero;
  logic signed [9:0] e;
  logic [22:0]       frac;

  assign done  = (s == 5'(DIV_STEPS));
  assign stall = run & ~done;

  // diff[25] is the borrow: set when the divisor does not fit.
  always_comb begin
    a    = (s == 5'd0) ? {1'b0, fp_mant(x)} : r;
    diff = {1'b0, a} - {2'b00, fp_mant(y)};
    qbit = ~diff[25];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= 5'd0;
      r <= 25'd0;
      q <= 26'd0;
    end else if (!run) begin
      s <= 5'd0;
    end else if (!done) begin
      r <= qbit ? (diff[24:0] << 1) : (a << 1);
      q <= {q[24:0], qbit};
      s <= s + 5'd1;
    end
  end

  always_comb begin
    sgn    = fp_sign(x) ^ fp_sign(y);
    x_zero = (fp_exp(x) == 8'd0);
    y_zero = (fp_exp(y) == 8'd0);
    e      = 10'(fp_exp(x)) - 10'(fp_exp(y))
           + (q[25] ? 10'(EXP_BIAS) : 10'(EXP_BIAS - 1));
    frac   = q[25] ? q[24:2] : q[23:1];

    if (y_zero)                z = {sgn, FP_INF_MAG};
    else if (x_zero)           z = 32'd0;
    else if (e <= 10'sd0)      z = 32'd0;
    else if (e >= 10'sd255)    z = {sgn, FP_INF_MAG};
    else                       z = {sgn, e[7:0], frac};
  end

endmodule

// File: tb/tb_fp_divider.sv
// Directed-vector bench for fp_divider: latency, quotient values, special
// operands, range limits and reset abort/restart.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] x;
  logic [31:0] y;
  logic        stall;
  logic [31:0] z;

  int n_vec = 0;
  int n_err = 0;

  fp_divider dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .x     (x),
    .y     (y),
    .stall (stall),
    .z     (z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Count rising edges until stall falls, bounded.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (stall && cycles < 60) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic do_div(input string tag, input logic [31:0] xv,
                        input logic [31:0] yv, input logic [31:0] zexp);
    int cyc;
    @(negedge clk);
    x   = xv;
    y   = yv;
    run = 1'b1;
    #1;
    chk({tag, " stall0"}, 32'(stall), 32'd1);
    wait_done(cyc);
    chk({tag, " cycles"}, 32'(cyc), 32'd26);
    chk({tag, " z"}, z, zexp);
    @(posedge clk);
    #1;
    chk({tag, " hold stall"}, 32'(stall), 32'd0);
    chk({tag, " hold z"}, z, zexp);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    run = 1'b0;
    x   = 32'h00000000;
    y   = 32'h40000000;
    #1;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset z", z, 32'd0);
    @(negedge clk);
    run = 1'b1;
    #1;
    chk("reset stall=run", 32'(stall), 32'd1);
    @(negedge clk);
    run = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    do_div("6/2",     32'h40C00000, 32'h40000000, 32'h40400000);
    do_div("1/3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
    do_div("-1/4",    32'hBF800000, 32'h40800000, 32'hBE800000);
    do_div("1/0",     32'h3F800000, 32'h00000000, 32'h7F800000);
    do_div("0/0",     32'h00000000, 32'h00000000, 32'h7F800000);
    do_div("0/2",     32'h00000000, 32'h40000000, 32'h00000000);
    do_div("ovf",     32'h7F000000, 32'h00800000, 32'h7F800000);
    do_div("unf",     32'h00800000, 32'h7F000000, 32'h00000000);

    // Abort after 10 stalled cycles, then a full restart with run held.
    @(negedge clk);
    x   = 32'h40C00000;
    y   = 32'h40000000;
    run = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst-mid stall", 32'(stall), 32'd1);
    // Q=0 selects the e=xe-ye+126 path with zero fraction: 1.0
    chk("rst-mid z", z, 32'h3F800000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst-mid stall after", 32'(stall), 32'd1);
    wait_done(cyc);
    chk("rst-mid cycles", 32'(cyc), 32'd26);
    chk("rst-mid z done", z, 32'h40400000);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_divider.md
# fp_divider

Multi-cycle single-precision floating-point divider for the RISC5 CPU's FDV instruction, alongside the pipelined adder and the multiplier in the execute stage. It computes z = x / y on 32-bit IEEE-754 operand bit patterns using restoring mantissa division, one quotient bit per cycle. It follows the same run/stall handshake as the other arithmetic units: the CPU holds `run`, `x` and `y` stable while `stall` is high.

## Interface
- No parameters; constants come from the shared package.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  divide request; held high by the CPU until `stall` falls.
- `x`  in  32  dividend, IEEE single.
- `y`  in  32  divisor, IEEE single.
- `stall`  out  1  high while a division is in progress.
- `z`  out  32  quotient; valid while `run`=1 and `stall`=0.

## Operation
- Field extraction:
  - xs = x[31], xe = x[30:23], xm = {1, x[22:0]}.
  - Same fields for y.
  - An operand is zero when its exponent field is 0; denormals are treated as zero.
- State registers:
  - step counter S, 5 bits, range 0..26.
  - partial remainder R, 25 bits.
  - quotient register Q, 26 bits.
- Division step, performed in every cycle with run=1 and S<26:
  - source A = (S==0) ? {0, xm} : R.
  - d = A − {0, ym}.
  - If d ≥ 0: q = 1 and R ← d<<1. Otherwise: q = 0 and R ← A<<1.
  - Q ← {Q[24:0], q}.
  - S ← S+1.
- Hold and restart:
  - With run=1 and S=26, S, R and Q hold.
  - With run=0, S ← 0. R and Q are don't-care; they are overwritten at S=0.
- Normalisation:
  - Q[25] is the integer bit.
  - If Q[25]=1: fraction = Q[24:2], e = xe − ye + 127.
  - Otherwise (Q[24] is then 1): fraction = Q[23:1], e = xe − ye + 126.
  - e is computed 10-bit signed; no rounding (truncation).
- Result, combinational from Q, x and y, in priority order:
  - y zero → {xs^ys, 8'hFF, 23'b0} (infinity, including 0/0).
  - x zero → 0.
  - e ≤ 0 → 0 (underflow).
  - e ≥ 255 → {xs^ys, 8'hFF, 23'b0} (overflow).
  - else {xs^ys, e[7:0], fraction}.
- Zero and infinity results do not shorten the operation: the full 26 cycles always run.

## Timing
- stall = run & (S != 26), combinational.
  - The first cycle of `run` stalls with no register delay.
- Latency: 26 stalled cycles; z is valid in the 27th cycle of `run`, the first cycle with stall=0.
  - The CPU deasserts `run` in the following cycle.
- Back-to-back operations: run must drop for at least one cycle between operations. A run held high past completion keeps z and stall=0 stable.
- Reset:
  - rst=1 forces S=0, R=0, Q=0 immediately.
  - Outputs during and after reset: stall = run; z is the combinational function of Q=0 (z=0 when x or y is zero).
- Reset mid-operation aborts the operation. If run is still high after rst drops, a full 26-cycle division restarts from S=0.
- Operand changes while stall=1 are illegal; the result is undefined.

## Structure
- Shared package `fp_pkg`:
  - `DIV_STEPS` = 26, `EXP_BIAS` = 127.
  - `FP_INF_MAG` = 31'h7F800000.
  - Field-extraction helpers for sign, exponent and mantissa. The multiplier and adder use these too.
- Single module. The datapath is one subtract/compare, and a sub-module would only add ports.

## Test plan
- 6.0/2.0: x=0x40C00000, y=0x40000000 → stall high exactly 26 cycles, then z=0x40400000.
- 1.0/3.0: x=0x3F800000, y=0x40400000 → z=0x3EAAAAAA (truncated, Q[25]=0 path).
- −1.0/4.0: x=0xBF800000, y=0x40800000 → z=0xBE800000.
- Special operands:
  - 1.0/0: x=0x3F800000, y=0 → z=0x7F800000.
  - 0/0 → 0x7F800000.
  - 0/2.0 → 0.
  - All three after the full 26 stall cycles.
- Range limits:
  - overflow: x=0x7F000000, y=0x00800000 → 0x7F800000.
  - underflow: swapped operands → 0.
- Reset mid-op: assert rst at stall cycle 10 with run held → stall stays high, and completion occurs 26 cycles after rst deasserts with the correct z.
